// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer and the control
// store that drives it.
//
// Contents:
//   pcmux_e               next-PC select encodings driven on i_PCMUX
//   PC_RESET_VEC_DEFAULT  default PC value loaded on reset
//   pcmux_legal()         true for the five defined select codes
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  // Next-PC source select. Codes 101-111 are illegal.
  typedef enum logic [2:0] {
    PCMUX_PC1    = 3'b000,
    PCMUX_BUS    = 3'b001,
    PCMUX_ADDER  = 3'b010,
    PCMUX_VECTOR = 3'b011,
    PCMUX_RETURN = 3'b100
  } pcmux_e;

  // LC-3 user programs conventionally start at x3000.
  localparam logic [15:0] PC_RESET_VEC_DEFAULT = 16'h3000;

  function automatic logic pcmux_legal(input logic [2:0] sel);
    return (sel <= 3'(PCMUX_RETURN));
  endfunction

endpackage

// File: rtl/pc_seq_ret_stack.sv
// ---------------------------------------------------------------------------
// pc_ret_stack
// Parametrised LIFO holding return addresses for vectored entries.
//
// Parameters:
//   WIDTH        entry width in bits
//   STACK_DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   i_CLK      clock, rising edge
//   i_RST_N    synchronous active-low reset (clears depth only)
//   i_Push     write i_Data on top of the stack (ignored when full)
//   i_Pop      discard the top entry (ignored when empty)
//   i_Data     value to push
//   o_Top      current top-of-stack entry (don't-care when empty)
//   o_Depth    number of occupied entries, 0..STACK_DEPTH
//   o_Full     depth == STACK_DEPTH
//   o_Empty    depth == 0
// ---------------------------------------------------------------------------
module pc_ret_stack #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  localparam int AW = $clog2(STACK_DEPTH),
  localparam int DW = $clog2(STACK_DEPTH) + 1
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Top,
  output logic [DW-1:0]    o_Depth,
  output logic             o_Full,
  output logic             o_Empty
);

  logic [WIDTH-1:0] r_Mem [STACK_DEPTH];
  logic [DW-1:0]    r_Depth;
  logic [AW-1:0]    w_WrIdx;
  logic [AW-1:0]    w_TopIdx;
  logic             w_DoPush;
  logic             w_DoPop;

  assign o_Full  = (r_Depth == DW'(STACK_DEPTH));
  assign o_Empty = (r_Depth == '0);

  // Depth is a power of two, so the low AW bits of the count address the
  // next free slot; at full depth they wrap to 0 and the top index
  // (count - 1) still lands on the last slot.
  assign w_WrIdx  = r_Depth[AW-1:0];
  assign w_TopIdx = r_Depth[AW-1:0] - AW'(1);

  assign w_DoPush = i_Push && !o_Full;
  assign w_DoPop  = i_Pop && !o_Empty;

  assign o_Top   = r_Mem[w_TopIdx];
  assign o_Depth = r_Depth;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_Depth <= '0;
    end else if (w_DoPush) begin
      r_Depth <= r_Depth + DW'(1);
    end else if (w_DoPop) begin
      r_Depth <= r_Depth - DW'(1);
    end
  end

  // Storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge i_CLK) begin
    if (i_RST_N && w_DoPush) begin
      r_Mem[w_WrIdx] <= i_Data;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq
// Program-counter sequencer for the LC-3 style datapath. Holds the PC,
// selects the next PC from PC+1 / bus / address adder / vector / return
// stack under control-store command, and flags misuse in a sticky error.
//
// Build option:
//   PC_STACK_EN  when defined, a hardware return-address stack is present:
//                VECTOR pushes the current PC, RETURN pops into the PC.
//                When undefined, VECTOR only loads the vector, RETURN
//                loads from the bus, and the stack outputs read as an
//                always-empty stack.
//
// Parameters:
//   WIDTH        PC/address width (>= 4)
//   RESET_VEC    PC value after reset
//   STACK_DEPTH  return-stack entries (power of two, >= 2)
//
// Ports:
//   i_CLK        clock, rising edge
//   i_RST_N      synchronous active-low reset
//   i_LD_PC      load enable; when low everything holds
//   i_PCMUX      next-PC select (see pc_seq_pkg::pcmux_e)
//   i_Bus        bus value
//   i_Addr       address-adder output
//   i_Vector     trap/interrupt vector
//   i_Clr_Err    clears o_Err (a same-cycle new error takes priority)
//   o_PC         current PC
//   o_PC_Plus1   PC + 1
//   o_Depth      occupied stack entries
//   o_Empty      stack empty
//   o_Full       stack full
//   o_Err        sticky error: illegal select, push on full, pop on empty
// ---------------------------------------------------------------------------
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(PC_RESET_VEC_DEFAULT),
  parameter int               STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH) + 1
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_LD_PC,
  input  logic [2:0]       i_PCMUX,
  input  logic [WIDTH-1:0] i_Bus,
  input  logic [WIDTH-1:0] i_Addr,
  input  logic [WIDTH-1:0] i_Vector,
  input  logic             i_Clr_Err,
  output logic [WIDTH-1:0] o_PC,
  output logic [WIDTH-1:0] o_PC_Plus1,
  output logic [DW-1:0]    o_Depth,
  output logic             o_Empty,
  output logic             o_Full,
  output logic             o_Err
);

  logic [WIDTH-1:0] r_PC;
  logic             r_Err;
  logic [WIDTH-1:0] w_NextPC;
  logic [WIDTH-1:0] w_PCPlus1;
  logic             w_ErrSet;

  assign w_PCPlus1 = r_PC + WIDTH'(1);

`ifdef PC_STACK_EN
  logic             w_Push;
  logic             w_Pop;
  logic [WIDTH-1:0] w_Top;
  logic [DW-1:0]    w_Depth;
  logic             w_Full;
  logic             w_Empty;

  // The current PC is pushed, so a RETURN resumes at the instruction
  // that was about to execute when the vector was taken.
  pc_ret_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_Push  (w_Push),
    .i_Pop   (w_Pop),
    .i_Data  (r_PC),
    .o_Top   (w_Top),
    .o_Depth (w_Depth),
    .o_Full  (w_Full),
    .o_Empty (w_Empty)
  );

  assign o_Depth = w_Depth;
  assign o_Empty = w_Empty;
  assign o_Full  = w_Full;
`else
  assign o_Depth = '0;
  assign o_Empty = 1'b1;
  assign o_Full  = 1'b0;
`endif

  // Next-PC selection and error detection. With the load enable low the
  // select is ignored entirely, so nothing can raise an error.
  always_comb begin
    w_NextPC = r_PC;
    w_ErrSet = 1'b0;
`ifdef PC_STACK_EN
    w_Push   = 1'b0;
    w_Pop    = 1'b0;
`endif
    if (i_LD_PC) begin
      if (!pcmux_legal(i_PCMUX)) begin
        w_ErrSet = 1'b1;
      end else begin
        case (i_PCMUX)
          PCMUX_PC1:    w_NextPC = w_PCPlus1;
          PCMUX_BUS:    w_NextPC = i_Bus;
          PCMUX_ADDER:  w_NextPC = i_Addr;
          PCMUX_VECTOR: begin
            // A full stack still takes the vector; only the push is lost.
            w_NextPC = i_Vector;
`ifdef PC_STACK_EN
            if (w_Full) begin
              w_ErrSet = 1'b1;
            end else begin
              w_Push = 1'b1;
            end
`endif
          end
          PCMUX_RETURN: begin
`ifdef PC_STACK_EN
            if (w_Empty) begin
              w_ErrSet = 1'b1;
            end else begin
              w_NextPC = w_Top;
              w_Pop    = 1'b1;
            end
`else
            // Without the stack, returns come back through memory on the bus.
            w_NextPC = i_Bus;
`endif
          end
          default: w_ErrSet = 1'b1;
        endcase
      end
    end
  end

  // A new error in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_PC  <= RESET_VEC;
      r_Err <= 1'b0;
    end else begin
      r_PC <= w_NextPC;
      if (w_ErrSet) begin
        r_Err <= 1'b1;
      end else if (i_Clr_Err) begin
        r_Err <= 1'b0;
      end
    end
  end

  assign o_PC       = r_PC;
  assign o_PC_Plus1 = w_PCPlus1;
  assign o_Err      = r_Err;

endmodule

// File: tb/tb_pc_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_seq
// Self-checking bench for pc_seq: directed scenarios followed by random
// operations, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pc_seq;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 4;
  localparam int          DW    = $clog2(DEPTH) + 1;
  localparam logic [15:0] RVEC  = 16'h3000;

  logic             i_CLK;
  logic             i_RST_N;
  logic             i_LD_PC;
  logic [2:0]       i_PCMUX;
  logic [WIDTH-1:0] i_Bus;
  logic [WIDTH-1:0] i_Addr;
  logic [WIDTH-1:0] i_Vector;
  logic             i_Clr_Err;
  logic [WIDTH-1:0] o_PC;
  logic [WIDTH-1:0] o_PC_Plus1;
  logic [DW-1:0]    o_Depth;
  logic             o_Empty;
  logic             o_Full;
  logic             o_Err;

  pc_seq #(
    .WIDTH       (WIDTH),
    .RESET_VEC   (RVEC),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .i_CLK      (i_CLK),
    .i_RST_N    (i_RST_N),
    .i_LD_PC    (i_LD_PC),
    .i_PCMUX    (i_PCMUX),
    .i_Bus      (i_Bus),
    .i_Addr     (i_Addr),
    .i_Vector   (i_Vector),
    .i_Clr_Err  (i_Clr_Err),
    .o_PC       (o_PC),
    .o_PC_Plus1 (o_PC_Plus1),
    .o_Depth    (o_Depth),
    .o_Empty    (o_Empty),
    .o_Full     (o_Full),
    .o_Err      (o_Err)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  // Reference model: PC as a plain number, return stack as a queue.
  logic [15:0] mPc;
  logic        mErr;
  logic [15:0] mStack[$];
  int          nChecks;
  int          nFails;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input logic rstn, input logic ld, input logic [2:0] mux,
                           input logic [15:0] bus, input logic [15:0] addr,
                           input logic [15:0] vec, input logic clr);
    logic err;
    err = 1'b0;
    if (!rstn) begin
      mPc  = RVEC;
      mErr = 1'b0;
      mStack.delete();
    end else begin
      if (ld) begin
        case (mux)
          3'd0: mPc = mPc + 16'd1;
          3'd1: mPc = bus;
          3'd2: mPc = addr;
          3'd3: begin
`ifdef PC_STACK_EN
            if (mStack.size() == DEPTH) err = 1'b1;
            else mStack.push_back(mPc);
`endif
            mPc = vec;
          end
          3'd4: begin
`ifdef PC_STACK_EN
            if (mStack.size() == 0) err = 1'b1;
            else mPc = mStack.pop_back();
`else
            mPc = bus;
`endif
          end
          default: err = 1'b1;
        endcase
      end
      if (err) mErr = 1'b1;
      else if (clr) mErr = 1'b0;
    end
  endtask

  task automatic checkAll();
    int sz;
    sz = mStack.size();
    checkOutput("pc", 32'(o_PC), 32'(mPc));
    checkOutput("pc_plus1", 32'(o_PC_Plus1), 32'(16'(mPc + 16'd1)));
    checkOutput("err", 32'(o_Err), 32'(mErr));
    checkOutput("depth", 32'(o_Depth), 32'(sz));
    checkOutput("empty", 32'(o_Empty), 32'(sz == 0));
    checkOutput("full", 32'(o_Full), 32'(sz == DEPTH));
  endtask

  // Drive one cycle of inputs, step the model at the edge, check #1 later.
  task automatic applyStimulus(input logic rstn, input logic ld, input logic [2:0] mux,
                               input logic [15:0] bus, input logic [15:0] addr,
                               input logic [15:0] vec, input logic clr);
    i_RST_N   = rstn;
    i_LD_PC   = ld;
    i_PCMUX   = mux;
    i_Bus     = bus;
    i_Addr    = addr;
    i_Vector  = vec;
    i_Clr_Err = clr;
    @(posedge i_CLK);
    modelStep(rstn, ld, mux, bus, addr, vec, clr);
    #1;
    checkAll();
  endtask

  task automatic op(input logic [2:0] mux, input logic [15:0] val);
    applyStimulus(1'b1, 1'b1, mux, val, val, val, 1'b0);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    mPc     = RVEC;
    mErr    = 1'b0;

    // Reset, with a load attempted alongside it to show reset wins.
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd1, 16'h5555, 16'h0, 16'h0, 1'b0);
    checkOutput("reset_pc", 32'(o_PC), 32'h3000);

    // Sequential increments then idle cycles.
    for (int i = 0; i < 3; i++) op(3'd0, 16'h0);
    applyStimulus(1'b1, 1'b0, 3'd1, 16'hBEEF, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd7, 16'hBEEF, 16'h0, 16'h0, 1'b0);
    checkOutput("hold_pc", 32'(o_PC), 32'h3003);
    checkOutput("hold_noerr", 32'(o_Err), 32'h0);

    // Bus load to all-ones, increment wraps, adder load.
    op(3'd1, 16'hFFFF);
    op(3'd0, 16'h0);
    checkOutput("wrap_pc", 32'(o_PC), 32'h0000);
    op(3'd2, 16'h1234);
    checkOutput("adder_pc", 32'(o_PC), 32'h1234);

    // Vector then return from 3005.
    op(3'd1, 16'h3005);
    op(3'd3, 16'h0180);
    checkOutput("vector_pc", 32'(o_PC), 32'h0180);
    applyStimulus(1'b1, 1'b1, 3'd4, 16'h1111, 16'h0, 16'h0, 1'b0);
`ifdef PC_STACK_EN
    checkOutput("return_pc", 32'(o_PC), 32'h3005);
`else
    checkOutput("return_pc", 32'(o_PC), 32'h1111);
`endif

    // Five vectors (overflow on the fifth), then four returns.
    for (int i = 0; i < 5; i++) op(3'd3, 16'(16'h0100 + i));
`ifdef PC_STACK_EN
    checkOutput("overflow_err", 32'(o_Err), 32'h1);
    checkOutput("overflow_depth", 32'(o_Depth), 32'h4);
`endif
    checkOutput("overflow_pc", 32'(o_PC), 32'h0104);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 3'd4, 16'(16'h2000 + i), 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1);

    // Return on empty, illegal select, then clear.
    op(3'd1, 16'h4000);
    applyStimulus(1'b1, 1'b1, 3'd4, 16'h2222, 16'h0, 16'h0, 1'b0);
`ifdef PC_STACK_EN
    checkOutput("underflow_pc", 32'(o_PC), 32'h4000);
    checkOutput("underflow_err", 32'(o_Err), 32'h1);
`else
    checkOutput("bus_return_pc", 32'(o_PC), 32'h2222);
`endif
    op(3'd6, 16'h9999);
    checkOutput("illegal_err", 32'(o_Err), 32'h1);
    // Clear together with a new error: error must win.
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h0, 16'h0, 16'h0, 1'b1);
    checkOutput("clr_vs_err", 32'(o_Err), 32'h1);
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1);
    checkOutput("clr_err", 32'(o_Err), 32'h0);

    // Back-to-back vector/return, then reset mid-sequence at depth 2.
    op(3'd3, 16'h0200);
    op(3'd4, 16'h0);
    op(3'd3, 16'h0300);
    op(3'd3, 16'h0310);
    op(3'd6, 16'h0);
    applyStimulus(1'b0, 1'b1, 3'd3, 16'h0, 16'h0, 16'h0400, 1'b0);
    checkOutput("midreset_pc", 32'(o_PC), 32'h3000);
    checkOutput("midreset_depth", 32'(o_Depth), 32'h0);
    checkOutput("midreset_err", 32'(o_Err), 32'h0);

    // Random operations.
    for (int n = 0; n < 600; n++) begin
      int          r;
      logic [2:0]  mux;
      logic        rstn;
      logic        ld;
      logic        clr;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 9: mux = 3'd0;
        2:       mux = 3'd1;
        3:       mux = 3'd2;
        4, 5:    mux = 3'd3;
        6, 7:    mux = 3'd4;
        default: mux = 3'(5 + $urandom_range(0, 2));
      endcase
      rstn = ($urandom_range(0, 63) != 0);
      ld   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 7) == 0);
      applyStimulus(rstn, ld, mux, 16'($urandom), 16'($urandom), 16'($urandom), clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer and successor to the LC-3 datapath's fixed 16-bit PC register. It holds the PC, selects the next PC from PC+1, the bus, the address adder or an interrupt/trap vector, and keeps a small hardware return-address stack so vectored entries and returns resolve in one cycle. It sits in the datapath under control-store command: it drives the bus gate and Addr1Mux, and takes the bus and adder outputs as next-PC sources.

## Interface
- WIDTH, 16, PC/address width in bits (≥4)
- RESET_VEC, 'h3000 (WIDTH bits), PC value loaded on reset
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)
- i_CLK  in  1  clock; all state updates on rising edge
- i_RST_N  in  1  reset: synchronous, active-low
- i_LD_PC  in  1  load enable from control store
- i_PCMUX  in  3  next-PC select: 000 PC+1, 001 BUS, 010 ADDER, 011 VECTOR, 100 RETURN, 101–111 illegal
- i_Bus  in  WIDTH  bus value
- i_Addr  in  WIDTH  address-adder output
- i_Vector  in  WIDTH  trap/interrupt vector address
- i_Clr_Err  in  1  clears o_Err
- o_PC  out  WIDTH  current PC
- o_PC_Plus1  out  WIDTH  PC+1 (combinational)
- o_Depth  out  clog2(STACK_DEPTH)+1  occupied stack entries
- o_Empty / o_Full  out  1  stack flags (combinational from o_Depth)
- o_Err  out  1  sticky error

## Operation
- Reset (i_RST_N=0 at edge): o_PC=RESET_VEC, o_Depth=0, o_Err=0; stack contents don't-care. Reset overrides every other input, including mid-operation loads.
- i_LD_PC=0: PC, stack and pointer hold; i_PCMUX ignored, so no errors are raised.
- i_LD_PC=1:
  - PC+1: PC←PC+1 mod 2^WIDTH, so all-ones wraps to 0.
  - BUS: PC←i_Bus.
  - ADDER: PC←i_Addr.
  - VECTOR: push current o_PC, then PC←i_Vector.
  - RETURN: PC←top of stack, then pop.
  - Illegal code: PC holds, o_Err←1.
- Push when full: PC still loads i_Vector; the push is dropped, depth is unchanged, o_Err←1.
- Pop when empty: PC holds, depth stays 0, o_Err←1.
- o_Err is sticky until i_Clr_Err=1 at an edge. If a new error and i_Clr_Err occur in the same cycle, the error wins and o_Err=1.
- The stack is LIFO. The pointer counts 0..STACK_DEPTH and never wraps.

## Timing
- Every load takes effect at the edge where i_LD_PC=1, with o_PC valid one cycle later. Single-cycle latency, no handshake, no stall from the block.
- o_PC_Plus1, o_Empty and o_Full are combinational from registered state only; there is no input→output combinational path.
- Back-to-back VECTOR/RETURN on consecutive cycles is legal. The stack read in a RETURN sees the push from the previous cycle.

## Configuration
- PC_STACK_EN defined: return stack, o_Depth, o_Empty/o_Full and the push/pop errors are present as above.
- PC_STACK_EN undefined: no stack storage. VECTOR loads i_Vector with no push. RETURN behaves as BUS (PC←i_Bus, the LC-3 RTI path through memory). o_Depth=0, o_Empty=1, o_Full=0. o_Err is set only by illegal codes.

## Structure
- Shared package holds the i_PCMUX encodings (PCMUX_PC1, PCMUX_BUS, PCMUX_ADDER, PCMUX_VECTOR, PCMUX_RETURN) and the RESET_VEC default. The control store uses the same constants.
- One sub-module, pc_ret_stack: parametrised LIFO (WIDTH, STACK_DEPTH) with push, pop, top, depth, full and empty. It is instantiated only under PC_STACK_EN.

## Test plan
- Reset, then 3 PC+1 loads → o_PC 3000, 3001, 3002, 3003. Hold i_LD_PC=0 for 2 cycles → stays 3003.
- Load BUS=FFFF, then PC+1 → o_PC FFFF, then 0000 (wrap). Load ADDER=1234 → 1234.
- From 3005: VECTOR 0180, then RETURN → o_PC 0180 with o_Depth 1, then 3005 with o_Depth 0 and o_Empty=1.
- Five consecutive VECTORs (depth 4) → o_Full after 4 pushes. 5th: PC loads vector, o_Err=1, depth stays 4. Four RETURNs unwind in LIFO order.
- RETURN on empty stack at PC 4000 → PC stays 4000, o_Err=1. Illegal code 110 → PC holds. i_Clr_Err → o_Err=0.
- Assert reset mid-sequence at depth 2 → o_PC=3000, o_Depth=0, o_Err=0. Without PC_STACK_EN, RETURN with bus=2222 → o_PC 2222.
